// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential adder/subtractor controller:
//   - state_t   : controller states (IDLE, RUN, DONE)
//   - OP_ADD/SUB: operation encoding carried on the 'op' input
//   - idx_width : width of the slice index counter (at least one bit)
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // A single-slice configuration still needs a one-bit counter to declare.
    function automatic int idx_width(input int n_slices);
        if (n_slices > 1) begin
            return $clog2(n_slices);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sumador_secuencial_if.sv
// -----------------------------------------------------------------------------
// sumador_secuencial_if
// Request/response bundle between the ALU control logic and the sequential
// adder.
//   master : drives start, op, a, b; observes ready, busy, done, result,
//            c_o, overflow
//   slave  : the adder side of the same signals
// -----------------------------------------------------------------------------
interface sumador_secuencial_if #(
    parameter int SLICE_W  = 6,
    parameter int N_SLICES = 4
);
    localparam int W = SLICE_W * N_SLICES;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_o;
    logic         overflow;

    modport master (
        output start, op, a, b,
        input  ready, busy, done, result, c_o, overflow
    );

    modport slave (
        input  start, op, a, b,
        output ready, busy, done, result, c_o, overflow
    );

endinterface

// File: rtl/sumador.sv
// -----------------------------------------------------------------------------
// sumador
// Purely combinational SLICE_W-bit adder slice with carry in/out.
//   num1, num2 : slice operands
//   c_1        : carry in
//   result     : slice sum
//   c_o        : carry out
// -----------------------------------------------------------------------------
module sumador #(
    parameter int SLICE_W = 6
) (
    input  logic [SLICE_W-1:0] num1,
    input  logic [SLICE_W-1:0] num2,
    input  logic               c_1,
    output logic [SLICE_W-1:0] result,
    output logic               c_o
);

    assign {c_o, result} = {1'b0, num1} + {1'b0, num2} + {{SLICE_W{1'b0}}, c_1};

endmodule

// File: rtl/sumador_secuencial.sv
// -----------------------------------------------------------------------------
// sumador_secuencial
// Wide-word adder/subtractor that reuses one SLICE_W-bit sumador slice over
// N_SLICES clock cycles, least significant chunk first, with the inter-slice
// carry held in a register.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of sumador_secuencial_if
//          start/op/a/b sampled in IDLE only; ready in IDLE, busy in RUN,
//          done pulses for one cycle in DONE; result/c_o/overflow registered
//          and held until the next operation overwrites them.
// -----------------------------------------------------------------------------
module sumador_secuencial
    import alu_pkg::*;
#(
    parameter int SLICE_W  = 6,
    parameter int N_SLICES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sumador_secuencial_if.slave  bus
);

    localparam int W     = SLICE_W * N_SLICES;
    localparam int IDX_W = idx_width(N_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [W-1:0]       opa_r;
    logic [W-1:0]       opb_r;
    logic [W-1:0]       result_r;
    logic               c_o_r;
    logic               overflow_r;
    logic               ready_r;
    logic               busy_r;
    logic               done_r;

    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic [SLICE_W-1:0] slice_sum_s;
    logic               slice_co_s;
    logic               last_s;

    // Select the operand chunk addressed by the slice index.
    always_comb begin
        slice_a_s = opa_r[int'(idx_r) * SLICE_W +: SLICE_W];
        slice_b_s = opb_r[int'(idx_r) * SLICE_W +: SLICE_W];
        last_s    = (idx_r == LAST_IDX);
    end

    sumador #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .num1   (slice_a_s),
        .num2   (slice_b_s),
        .c_1    (carry_r),
        .result (slice_sum_s),
        .c_o    (slice_co_s)
    );

    // Next-state logic of the controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == IDLE);
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand capture, slice sequencing and result/flag accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_r      <= {W{1'b0}};
            opb_r      <= {W{1'b0}};
            carry_r    <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
            result_r   <= {W{1'b0}};
            c_o_r      <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: invert B, seed carry with 1.
                        opa_r   <= bus.a;
                        opb_r   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        carry_r <= (bus.op == OP_SUB);
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    result_r[int'(idx_r) * SLICE_W +: SLICE_W] <= slice_sum_s;
                    carry_r <= slice_co_s;
                    if (last_s) begin
                        // Index parks at 0 so it never addresses past the operand.
                        idx_r      <= {IDX_W{1'b0}};
                        c_o_r      <= slice_co_s;
                        // MSB sum bit ^ both MSB operand bits = carry into MSB.
                        overflow_r <= opa_r[W-1] ^ opb_r[W-1]
                                      ^ slice_sum_s[SLICE_W-1] ^ slice_co_s;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready    = ready_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.c_o      = c_o_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_sumador_secuencial.sv
// -----------------------------------------------------------------------------
// tb_sumador_secuencial
// Directed self-checking bench for sumador_secuencial (default W=24).
// Expected results come from a full-width reference model pushed into a
// scoreboard queue when an operation is launched and popped when done rises.
// -----------------------------------------------------------------------------
module tb_sumador_secuencial;
    import alu_pkg::*;

    localparam int SLICE_W  = 6;
    localparam int N_SLICES = 4;
    localparam int W        = SLICE_W * N_SLICES;
    localparam int LAT      = N_SLICES;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;
    exp_t exp_q[$];

    sumador_secuencial_if #(.SLICE_W(SLICE_W), .N_SLICES(N_SLICES)) bus ();

    sumador_secuencial #(
        .SLICE_W  (SLICE_W),
        .N_SLICES (N_SLICES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   s;
        bb    = (op == OP_SUB) ? ~b : b;
        s     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op};
        e.res = s[W-1:0];
        e.co  = s[W];
        e.ovf = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at an IDLE edge; returns #1 after the accepting edge E0.
    task automatic launch(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        chk("ready_low_after_start", 32'(bus.ready), 32'd0);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    // Wait (bounded) for done, check latency and pop/compare the scoreboard.
    task automatic collect(input string tag, input int exp_lat);
        int   cnt;
        exp_t e;
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, 32'(bus.result), 32'(e.res));
            chk({tag, "_c_o"}, 32'(bus.c_o), 32'(e.co));
            chk({tag, "_overflow"}, 32'(bus.overflow), 32'(e.ovf));
            chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        end
    endtask

    // Step one edge past DONE and confirm the return to IDLE.
    task automatic back_to_idle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_cleared"}, 32'(bus.done), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    endtask

    // Directed test sequence.
    initial begin
        vectors   = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = {W{1'b0}};
        bus.b     = {W{1'b0}};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_c_o", 32'(bus.c_o), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Inter-slice carry out of slice 0; result constant cross-check.
        launch(OP_ADD, 24'h00003F, 24'h000002);
        collect("add_3f_2", LAT);
        chk("add_3f_2_const", 32'(bus.result), 32'h00000041);
        back_to_idle("add_3f_2");

        // Full ripple across every slice.
        launch(OP_ADD, 24'hFFFFFF, 24'h000001);
        collect("add_ripple", LAT);
        chk("add_ripple_c_o_const", 32'(bus.c_o), 32'd1);
        back_to_idle("add_ripple");

        // Positive signed overflow.
        launch(OP_ADD, 24'h7FFFFF, 24'h000001);
        collect("add_ovf", LAT);
        chk("add_ovf_const", 32'(bus.overflow), 32'd1);
        back_to_idle("add_ovf");

        // Subtract with borrow, then without.
        launch(OP_SUB, 24'h000005, 24'h000007);
        collect("sub_5_7", LAT);
        chk("sub_5_7_const", 32'(bus.result), 32'h00FFFFFE);
        back_to_idle("sub_5_7");
        launch(OP_SUB, 24'h000007, 24'h000005);
        collect("sub_7_5", LAT);
        chk("sub_7_5_c_o_const", 32'(bus.c_o), 32'd1);
        back_to_idle("sub_7_5");

        // Start pulsed during RUN with other operands must be ignored.
        launch(OP_ADD, 24'h123456, 24'h111111);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = OP_SUB;
        bus.a     = 24'h000001;
        bus.b     = 24'h0ABCDE;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        collect("ignore_run", LAT - 2);

        // Start held through DONE: accepted on the first IDLE edge.
        bus.start = 1'b1;
        bus.op    = OP_SUB;
        bus.a     = 24'h800000;
        bus.b     = 24'h000001;
        chk("hold_ready_in_done", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        chk("hold_ready_idle", 32'(bus.ready), 32'd1);
        launch(OP_SUB, 24'h800000, 24'h000001);
        collect("held_start", LAT);
        back_to_idle("held_start");

        // Reset after slice 1 aborts the operation immediately.
        launch(OP_ADD, 24'hFFFFFF, 24'hFFFFFF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        launch(OP_ADD, 24'h000010, 24'h000020);
        collect("after_abort", LAT);
        chk("after_abort_const", 32'(bus.result), 32'h00000030);
        back_to_idle("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global safety net in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sumador_secuencial.md
Name: sumador_secuencial

Overview:
- Sequential wide-word adder/subtractor controller built around one shared narrow `sumador` slice.
- Splits W-bit operands into N_SLICES chunks of SLICE_W bits. Feeds one chunk per clock through the slice, LSB chunk first.
- Chains each slice's carry-out into the next slice's carry-in through a register.
- Sits between the ALU control logic and the adder datapath, trading latency for area on wide operands.

Parameters:
- SLICE_W, 6, width of the instantiated sumador slice in bits.
- N_SLICES, 4, number of slices per operation; total width W = SLICE_W*N_SLICES (24 by default).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- ready  out  1  high only in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- result  out  W  registered sum/difference; holds the last value until the next operation writes it.
- c_o  out  1  final carry-out; for subtract, 1 means no borrow.
- overflow  out  1  two's-complement signed overflow of the full-width operation.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE, slice index=0, carry register=0.
  - result=0, c_o=0, overflow=0, done=0, busy=0, ready=1.
- Reset mid-operation aborts immediately. No partial result is retained; the block restarts in IDLE.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on a clock edge where start=1. On that edge (E0):
  - Latch opA=a and opB=(op ? ~b : b).
  - Set carry=op, idx=0.
  - result is not cleared at E0.
- RUN, each edge:
  - Slice inputs: num1=opA[idx*SLICE_W +: SLICE_W], num2=opB[same range], c_1=carry.
  - Write the slice output into result[idx*SLICE_W +: SLICE_W].
  - carry <= slice c_o; idx <= idx+1.
  - On the edge where idx==N_SLICES-1, also:
    - c_o <= slice c_o.
    - overflow <= opA[W-1] ^ opB[W-1] ^ slice_result[SLICE_W-1] ^ slice_c_o (carry into MSB XOR carry out).
    - state <= DONE.
- DONE -> IDLE unconditionally on the next edge.
- Latency, with start sampled at edge E0:
  - Slices 0..N_SLICES-1 are processed at edges E1..E_N.
  - done=1 for exactly the cycle between E_N and E_N+1.
  - ready returns at E_N+1.
  - Default: done appears 4 cycles after E0; the start-to-start period is 6 cycles.
- Intermediate result values are visible during RUN (upper slices still hold old data). Consumers use result only at or after done.
- start is ignored in RUN and DONE, with no queueing. A start held high through DONE is accepted on the first IDLE edge.
- Operand inputs may change freely after E0; they are never re-sampled.
- c_o and overflow hold their values until the next operation's final slice writes them.
- Arithmetic wraps modulo 2^W.
- Subtract uses ~b with carry-in 1.
- The slice index counter is $clog2(N_SLICES) bits wide; N_SLICES=1 is legal: a single RUN cycle, with idx fixed at 0.

Decomposition:
- Shared package alu_pkg:
  - State enum typedef (IDLE, RUN, DONE).
  - Op encoding constants (OP_ADD=1'b0, OP_SUB=1'b1).
- One sub-module: the existing sumador #(SLICE_W) instantiated once, purely combinational.
- All sequencing, operand registers, carry register and overflow logic live in sumador_secuencial.

Test Plan (defaults, W=24):
- Add 0x00003F + 0x000002 -> result=0x000041, c_o=0, overflow=0; done high exactly 4 cycles after the start edge; inter-slice carry verified.
- Add 0xFFFFFF + 0x000001 -> result=0x000000, c_o=1, overflow=0 (full carry ripple across all 4 slices).
- Add 0x7FFFFF + 0x000001 -> result=0x800000, c_o=0, overflow=1.
- Subtract: 5 - 7 -> result=0xFFFFFE, c_o=0, overflow=0. Then 7 - 5 -> result=0x000002, c_o=1.
- Pulse start again during RUN with different operands -> ignored; first result unchanged. Hold start high through DONE -> second operation accepted at the first IDLE edge; ready=0 during it.
- Assert rst for 1 cycle mid-RUN (after slice 1) -> immediately result=0, done=0, busy=0, ready=1. A following add 0x000010 + 0x000020 -> 0x000030.
